// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM:
// opcodes, state encodings, ALUOp codes and datapath select codes.
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_ADDI = 6'd8;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Dispatch target out of DECODE; anything unsupported traps.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_R:         nxt = S_EXEC;
            OP_BEQ:       nxt = S_BRANCH;
            OP_J:         nxt = S_JUMP;
            OP_ADDI:      nxt = S_ADDIEX;
            default:      nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_out_dec.sv
// Combinational decode of FSM state (plus mem_ready) into every datapath
// control output; write strobes are held low while reset is asserted.
module mc_out_dec
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       rst,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       instr_done,
    output logic       trap
);

    logic pc_write_s;
    logic pc_write_cond_s;
    logic mem_read_s;
    logic mem_write_s;
    logic ir_write_s;
    logic reg_write_s;

    // Per-state control word; everything defaults to the inactive value.
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_write_s     = 1'b0;
        iord            = 1'b0;
        mem_to_reg      = 1'b0;
        pc_source       = PCSRC_ALU;
        alu_op          = ALUOP_ADD;
        alu_src_a       = 1'b0;
        alu_src_b       = SRCB_RT;
        reg_dst         = 1'b0;
        instr_done      = 1'b0;
        trap            = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord       = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
                instr_done  = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                iord        = 1'b1;
                instr_done  = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
                instr_done  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = ALUOP_SUB;
                pc_write_cond_s = 1'b1;
                pc_source       = PCSRC_ALUOUT;
                instr_done      = 1'b1;
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_IMM;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
                instr_done  = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b1;
            end
        endcase
    end

    // Reset returns the FSM to FETCH asynchronously; mask its strobes too.
    assign pc_write      = pc_write_s      & ~rst;
    assign pc_write_cond = pc_write_cond_s & ~rst;
    assign mem_read      = mem_read_s      & ~rst;
    assign mem_write     = mem_write_s     & ~rst;
    assign ir_write      = ir_write_s      & ~rst;
    assign reg_write     = reg_write_s     & ~rst;

endmodule

// File: rtl/mc_main_ctl.sv
// Main control FSM of the multi-cycle MIPS datapath: state register,
// next-state logic and retired-instruction counter.
module mc_main_ctl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             instr_done,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             trap,
    output logic [3:0]       state_dbg
);

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   retire_cnt_r;
    logic               instr_done_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; memory states stall until mem_ready.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) next_state_s = S_DECODE;
                else           next_state_s = S_FETCH;
            end
            S_DECODE: next_state_s = decode_next(Op);
            S_MEMADR: begin
                if (Op == OP_LW)      next_state_s = S_MEMRD;
                else if (Op == OP_SW) next_state_s = S_MEMWR;
                else                  next_state_s = S_TRAP;
            end
            S_MEMRD: begin
                if (mem_ready) next_state_s = S_MEMWB;
                else           next_state_s = S_MEMRD;
            end
            S_MEMWR: begin
                if (mem_ready) next_state_s = S_FETCH;
                else           next_state_s = S_MEMWR;
            end
            S_EXEC:   next_state_s = S_RWB;
            S_ADDIEX: next_state_s = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: next_state_s = S_FETCH;
            S_TRAP:   next_state_s = S_TRAP;
            default:  next_state_s = S_TRAP;
        endcase
    end

    // Retired-instruction counter; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_r <= '0;
        end else if (instr_done_s) begin
            retire_cnt_r <= retire_cnt_r + CNT_W'(1);
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    mc_out_dec u_out_dec (
        .state         (state_r),
        .mem_ready     (mem_ready),
        .rst           (rst),
        .pc_write      (PCWrite),
        .pc_write_cond (PCWriteCond),
        .iord          (IorD),
        .mem_read      (MemRead),
        .mem_write     (MemWrite),
        .mem_to_reg    (MemtoReg),
        .ir_write      (IRWrite),
        .pc_source     (PCSource),
        .alu_op        (ALUOp),
        .alu_src_a     (ALUSrcA),
        .alu_src_b     (ALUSrcB),
        .reg_write     (RegWrite),
        .reg_dst       (RegDst),
        .instr_done    (instr_done_s),
        .trap          (trap)
    );

    assign instr_done = instr_done_s;
    assign retire_cnt = retire_cnt_r;
    assign state_dbg  = state_r;

endmodule
